// File: rtl/conv_tile_scheduler_if.sv
// Tile descriptor channel between the layer scheduler (master) and the PE array (slave).
interface conv_tile_scheduler_if #(
    parameter int WADDR_W = 12
);
    logic               tile_valid;
    logic               tile_ready;
    logic [7:0]         tile_x;
    logic [7:0]         tile_y;
    logic [3:0]         id_idx;
    logic [7:0]         od_idx;
    logic [WADDR_W-1:0] weight_addr;
    logic               acc_first;
    logic               acc_last;

    modport master (
        output tile_valid, tile_x, tile_y, id_idx, od_idx, weight_addr, acc_first, acc_last,
        input  tile_ready
    );

    modport slave (
        input  tile_valid, tile_x, tile_y, id_idx, od_idx, weight_addr, acc_first, acc_last,
        output tile_ready
    );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: walks the id/tile_x/tile_y/od nest and issues one Winograd tile descriptor per transfer.
// Optional macro SCHED_PERF_CNT_EN enables the saturating tile_valid stall counter on stall_cnt.
module conv_tile_scheduler #(
    parameter int WADDR_W   = 12,
    parameter int DRAIN_CYC = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            total_id,
    input  logic [7:0]            total_od,
    input  logic [8:0]            total_width,
    input  logic [8:0]            total_height,
    input  logic                  total_size_type,
    conv_tile_scheduler_if.master tile,
    output logic                  busy,
    output logic                  conv_completed,
    output logic [15:0]           stall_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         id_q, id_d, id_max_q, id_max_d, tid_q, tid_d;
    logic [7:0]         x_q, x_d, x_max_q, x_max_d;
    logic [7:0]         y_q, y_d, y_max_q, y_max_d;
    logic [7:0]         od_q, od_d, od_max_q, od_max_d;
    logic [7:0]         drain_q, drain_d;
    logic [WADDR_W-1:0] w_base_q, w_base_d;

    logic [8:0] out_w, out_h;
    logic [9:0] sum_w, sum_h;
    logic [7:0] tiles_x, tiles_y;
    logic       degen;
    logic       last_id, last_x, last_y, last_od;

    // ceil(out/m) as (out + m - 1) >> log2(m); the 10-bit sum avoids overflow at W=511
    always_comb begin
        out_w   = total_width  - 9'd2;
        out_h   = total_height - 9'd2;
        sum_w   = {1'b0, out_w} + (total_size_type ? 10'd3 : 10'd1);
        sum_h   = {1'b0, out_h} + (total_size_type ? 10'd3 : 10'd1);
        tiles_x = total_size_type ? 8'(sum_w >> 2) : 8'(sum_w >> 1);
        tiles_y = total_size_type ? 8'(sum_h >> 2) : 8'(sum_h >> 1);
        degen   = (total_id == 4'd0) || (total_od == 8'd0) ||
                  (total_width < 9'd3) || (total_height < 9'd3);
    end

    assign last_id = (id_q == id_max_q);
    assign last_x  = (x_q  == x_max_q);
    assign last_y  = (y_q  == y_max_q);
    assign last_od = (od_q == od_max_q);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        x_d      = x_q;
        y_d      = y_q;
        od_d     = od_q;
        w_base_d = w_base_q;
        tid_d    = tid_q;
        id_max_d = id_max_q;
        x_max_d  = x_max_q;
        y_max_d  = y_max_q;
        od_max_d = od_max_q;
        drain_d  = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tid_d    = total_id;
                    id_max_d = total_id - 4'd1;
                    x_max_d  = tiles_x - 8'd1;
                    y_max_d  = tiles_y - 8'd1;
                    od_max_d = total_od - 8'd1;
                    id_d     = '0;
                    x_d      = '0;
                    y_d      = '0;
                    od_d     = '0;
                    w_base_d = '0;
                    state_d  = degen ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // every index wraps to 0 on the final transfer, so IDLE sees a cleared descriptor
                if (tile.tile_ready) begin
                    if (!last_id) begin
                        id_d = id_q + 4'd1;
                    end else begin
                        id_d = '0;
                        if (!last_x) begin
                            x_d = x_q + 8'd1;
                        end else begin
                            x_d = '0;
                            if (!last_y) begin
                                y_d = y_q + 8'd1;
                            end else begin
                                y_d = '0;
                                if (!last_od) begin
                                    od_d     = od_q + 8'd1;
                                    w_base_d = w_base_q + WADDR_W'(tid_q);
                                end else begin
                                    od_d     = '0;
                                    w_base_d = '0;
                                    drain_d  = 8'(DRAIN_CYC - 1);
                                    state_d  = DRAIN;
                                end
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 8'd0) state_d = DONE;
                else                 drain_d = drain_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            id_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            od_q     <= '0;
            w_base_q <= '0;
            tid_q    <= '0;
            id_max_q <= '0;
            x_max_q  <= '0;
            y_max_q  <= '0;
            od_max_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            x_q      <= x_d;
            y_q      <= y_d;
            od_q     <= od_d;
            w_base_q <= w_base_d;
            tid_q    <= tid_d;
            id_max_q <= id_max_d;
            x_max_q  <= x_max_d;
            y_max_q  <= y_max_d;
            od_max_q <= od_max_d;
            drain_q  <= drain_d;
        end
    end

    assign tile.tile_valid  = (state_q == ISSUE);
    assign tile.tile_x      = x_q;
    assign tile.tile_y      = y_q;
    assign tile.id_idx      = id_q;
    assign tile.od_idx      = od_q;
    assign tile.weight_addr = w_base_q + WADDR_W'(id_q);
    assign tile.acc_first   = tile.tile_valid && (id_q == 4'd0);
    assign tile.acc_last    = tile.tile_valid && last_id;
    assign busy             = (state_q != IDLE);
    assign conv_completed   = (state_q == DONE);

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start)
            stall_d = '0;
        else if (tile.tile_valid && !tile.tile_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: index sequence, handshake, drain timing, degenerate and reset cases.
module tb_conv_tile_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  total_id = '0;
    logic [7:0]  total_od = '0;
    logic [8:0]  total_width = '0;
    logic [8:0]  total_height = '0;
    logic        total_size_type = 1'b0;
    logic        busy, conv_completed;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    conv_tile_scheduler_if #(.WADDR_W(12)) tif();

    conv_tile_scheduler #(.WADDR_W(12), .DRAIN_CYC(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .total_id        (total_id),
        .total_od        (total_od),
        .total_width     (total_width),
        .total_height    (total_height),
        .total_size_type (total_size_type),
        .tile            (tif),
        .busy            (busy),
        .conv_completed  (conv_completed),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    // Runs one layer from IDLE; expected sequence is built by plain nested loops (od, y, x, id).
    task automatic run_layer(input string tag, input int w, input int h, input int tid, input int tod,
                             input int typ, input int exp_n, input bit bp, input bit poke);
        int q_id[$], q_x[$], q_y[$], q_od[$];
        int m, tx, ty, n, stalls, errs, obs, last_t, comp_t, busy_n;
        bit done, prev_stall;
        m  = (typ != 0) ? 4 : 2;
        tx = (w < 3) ? 0 : ((w - 2) + m - 1) / m;
        ty = (h < 3) ? 0 : ((h - 2) + m - 1) / m;
        if (tid > 0 && tod > 0)
            for (int o = 0; o < tod; o++)
                for (int yy = 0; yy < ty; yy++)
                    for (int xx = 0; xx < tx; xx++)
                        for (int i = 0; i < tid; i++) begin
                            q_id.push_back(i); q_x.push_back(xx);
                            q_y.push_back(yy); q_od.push_back(o);
                        end
        total_width = 9'(w); total_height = 9'(h); total_id = 4'(tid);
        total_od = 8'(tod); total_size_type = 1'(typ);
        start = 1'b1;
        tif.tile_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; stalls = 0; errs = 0; obs = 0; last_t = -1; comp_t = -1; busy_n = 0;
        done = 1'b0; prev_stall = 1'b0;
        chk({tag, "_first_valid"}, 32'(tif.tile_valid), 32'(exp_n > 0));
        while (!done && obs < 20000) begin
            if (poke && obs == 5) begin
                start = 1'b1;
                total_od = 8'(tod + 3);
            end else if (poke && obs == 6) begin
                start = 1'b0;
            end
            tif.tile_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy) busy_n++;
            if (tif.tile_valid) begin
                if (q_id.size() == 0) begin
                    errs++;
                end else if (int'(tif.id_idx) != q_id[0] || int'(tif.tile_x) != q_x[0] ||
                             int'(tif.tile_y) != q_y[0] || int'(tif.od_idx) != q_od[0] ||
                             int'(tif.weight_addr) != q_od[0] * tid + q_id[0] ||
                             tif.acc_first != (q_id[0] == 0) || tif.acc_last != (q_id[0] == tid - 1)) begin
                    errs++;
                end
                if (tif.tile_ready) begin
                    if (q_id.size() > 0) begin
                        void'(q_id.pop_front()); void'(q_x.pop_front());
                        void'(q_y.pop_front());  void'(q_od.pop_front());
                    end
                    n++;
                    last_t = obs;
                end else begin
                    stalls++;
                end
            end else if (prev_stall) begin
                errs++;
            end
            prev_stall = tif.tile_valid && !tif.tile_ready;
            if (conv_completed) begin
                done = 1'b1;
                comp_t = obs;
            end else begin
                @(posedge clk); #1;
                obs++;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_xfers"}, 32'(n), 32'(exp_n));
        chk({tag, "_seq_errs"}, 32'(errs), 32'd0);
        chk({tag, "_left"}, 32'(q_id.size()), 32'd0);
        if (exp_n > 0) chk({tag, "_drain_lat"}, 32'(comp_t - last_t), 32'd9);
        else           chk({tag, "_degen_lat"}, 32'(comp_t), 32'd0);
        if (!bp && exp_n > 0) chk({tag, "_no_bubble"}, 32'(last_t), 32'(exp_n - 1));
        chk({tag, "_busy_cyc"}, 32'(busy_n), 32'(comp_t + 1));
`ifdef SCHED_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(stalls));
`else
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pulse_once"}, 32'(conv_completed), 32'd0);
        total_od = 8'(tod);
    endtask

    initial begin
        int seen;
        tif.tile_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(tif.tile_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_completed", 32'(conv_completed), 32'd0);
        chk("rst_acc_first", 32'(tif.acc_first), 32'd0);
        chk("rst_waddr", 32'(tif.weight_addr), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_layer("l30_t0", 30, 30, 2, 4, 0, 1568, 1'b0, 1'b0);
        run_layer("l30_t1", 30, 30, 2, 4, 1, 392, 1'b0, 1'b0);
        run_layer("w31_t1", 31, 30, 2, 4, 1, 448, 1'b0, 1'b0);
        run_layer("bp50", 30, 30, 2, 4, 0, 1568, 1'b1, 1'b0);
        run_layer("id1", 5, 5, 1, 2, 0, 8, 1'b1, 1'b0);
        run_layer("id0", 30, 30, 0, 4, 0, 0, 1'b0, 1'b0);
        run_layer("w2", 2, 30, 2, 4, 0, 0, 1'b0, 1'b0);
        run_layer("poke", 10, 10, 2, 3, 0, 96, 1'b0, 1'b1);

        // reset in the middle of ISSUE
        total_width = 9'd30; total_height = 9'd30; total_id = 4'd2; total_od = 8'd4;
        total_size_type = 1'b0;
        start = 1'b1;
        tif.tile_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_valid", 32'(tif.tile_valid), 32'd1);
        chk("mid_tile_x", 32'(tif.tile_x), 32'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_valid", 32'(tif.tile_valid), 32'd0);
        chk("mrst_tile_x", 32'(tif.tile_x), 32'd0);
        chk("mrst_id", 32'(tif.id_idx), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_completed", 32'(conv_completed), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (conv_completed || tif.tile_valid) seen++;
        end
        chk("mrst_quiet", 32'(seen), 32'd0);
        run_layer("after_rst", 7, 9, 3, 2, 1, 24, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Layer-level sequencer for the Winograd convolution datapath. On `start` it latches the layer configuration and issues one tile descriptor per cycle (input-depth index, tile row/column, output-depth index, weight address, accumulate flags) to the PE array over a valid/ready handshake. It sits between the top-level controller registers (`total_*`, `wen`) and the data/weight memory read ports plus the PE accumulators. When the last tile has drained, it pulses `conv_completed`.

## Interface
Parameters:
- `WADDR_W`, default 12: weight address width; must hold 255*15+14.
- `DRAIN_CYC`, default 8: cycles to wait after the last issue for the PE pipeline to empty (range 1..255).

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a layer; sampled only in IDLE.
- `total_id` in 4: input depth count.
- `total_od` in 8: output depth count.
- `total_width` in 9: input plane width.
- `total_height` in 9: input plane height.
- `total_size_type` in 1: tile type; 0 = F(2x2,3x3) with m=2, 1 = F(4x4,3x3) with m=4.
- `tile_valid` out 1: descriptor valid.
- `tile_ready` in 1: PE accepts the descriptor.
- `tile_x` out 8: tile column index.
- `tile_y` out 8: tile row index.
- `id_idx` out 4: input depth index.
- `od_idx` out 8: output depth index.
- `weight_addr` out WADDR_W: equals od_idx*total_id + id_idx.
- `acc_first` out 1: descriptor has id_idx==0; PE clears its accumulator.
- `acc_last` out 1: descriptor has id_idx==total_id-1; PE writes back.
- `busy` out 1: high in any state other than IDLE.
- `conv_completed` out 1: one-cycle pulse at the end of a layer.
- `stall_cnt` out 16: stall counter (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- In IDLE with `start`=1:
  - Latch all `total_*` inputs. Later input changes are ignored until the next start.
  - Compute out_w = W-2 and out_h = H-2.
  - Compute tiles_x = ceil(out_w/m) and tiles_y = ceil(out_h/m), using shift-based division.
  - Go to ISSUE.
- Degenerate config: `total_id`==0, `total_od`==0, W<3 or H<3. On `start`, go straight to DONE. No tile is issued.
- Loop order, innermost first: id_idx, tile_x, tile_y, od_idx. id_idx is innermost so accumulation completes per tile before the next tile starts.
- Each transfer (`tile_valid && tile_ready`) advances the nest.
  - id_idx wraps at total_id-1 and carries into tile_x.
  - tile_x wraps at tiles_x-1 and carries into tile_y.
  - tile_y wraps at tiles_y-1 and carries into od_idx.
- Weight address is kept incrementally, with no multiplier.
  - w_base starts at 0 and adds total_id whenever od_idx advances.
  - weight_addr = w_base + id_idx.
- A transfer with all indices at their maximum is the final transfer. ISSUE then goes to DRAIN and `tile_valid` drops the next cycle.
- DRAIN counts DRAIN_CYC cycles, then goes to DONE.
- DONE lasts one cycle with `conv_completed`=1, then returns to IDLE.
- `start` in any state other than IDLE is ignored.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values. No `conv_completed` pulse is produced.
- Partial last tile (out_w not a multiple of m) is still issued. Edge masking belongs to the PE.

## Timing
- Reset values: all outputs 0, state IDLE.
- Issue latency:
  - `start` is sampled at edge N.
  - `tile_valid`=1 with the first descriptor (all indices 0, `acc_first`=1) from edge N+1.
- Handshake rules:
  - While `tile_valid && !tile_ready`, every descriptor output holds stable.
  - `tile_valid` never drops before the transfer completes.
- Throughput is one descriptor per cycle under continuous `tile_ready`. There are no bubbles across wraps.
- `acc_first` and `acc_last` are both 1 on every descriptor when `total_id`==1.
- `conv_completed` is asserted exactly DRAIN_CYC+1 cycles after the final transfer edge.
- Degenerate config: `conv_completed` is asserted 1 cycle after `start`.
- `busy` rises the cycle after `start` and falls with the cycle after `conv_completed`.

## Configuration
- `SCHED_PERF_CNT_EN` defined:
  - `stall_cnt` increments (saturating at 16'hFFFF) on each cycle with `tile_valid && !tile_ready`.
  - Cleared on `reset` and when `start` is accepted.
- Not defined: `stall_cnt` is constant 0 and no counter logic is synthesized.

## Test plan
- W=H=30, id=2, od=4, type 0, ready held 1 → exactly 14*14*2*4=1568 transfers with a strict loop-order index sequence. The last descriptor is (tx=13, ty=13, id=1, od=3) with weight_addr=7. `conv_completed` is asserted 9 cycles after the last transfer.
- Same layer with type 1 → 7*7*2*4=392 transfers. W=31 with type 1 → tiles_x=8 (partial tile issued).
- Random `tile_ready` backpressure at 50% → descriptors stay stable during stalls and the sequence is identical to the no-stall case. With the macro defined, `stall_cnt` equals the counted stall cycles.
- total_id=0, or W=2 → no `tile_valid`, `conv_completed` asserted 1 cycle after `start`, `busy` high for exactly 1 cycle.
- `start` pulsed during ISSUE with a changed `total_od` → ignored; the transfer count matches the original config.
- `reset` asserted mid-ISSUE → all outputs 0 the next cycle, no `conv_completed`. A following `start` restarts from index 0.
